// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the multiplier result packer.
package mul_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned CNT_W = 6;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/denorm_shifter.sv
// Right-shifts a mantissa one bit per step, collecting shifted-out bits into a sticky flag.
module denorm_shifter #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [CNT_W-1:0]  count_in,
    output logic [MANT_W-1:0] mant_nx,
    output logic              sticky_nx,
    output logic              done
);

    logic [MANT_W-1:0] mant_q, mant_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // mant_nx/sticky_nx are the values after the current step, so the
    // final step's result can be captured on the same edge it is taken.
    always_comb begin
        mant_nx   = mant_q >> 1;
        sticky_nx = sticky_q | mant_q[0];
        done      = (cnt_q == CNT_W'(1));
        mant_d    = mant_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        if (load) begin
            mant_d   = mant_in;
            sticky_d = 1'b0;
            cnt_d    = count_in;
        end else if (step && (cnt_q != '0)) begin
            mant_d   = mant_nx;
            sticky_d = sticky_nx;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_result_packer.sv
// Packs sign/exponent/mantissa into an IEEE-754 word, denormalizing on underflow by truncation.
module mul_result_packer #(
    parameter int unsigned EXP_W  = mul_pkg::EXP_W,
    parameter int unsigned FRAC_W = mul_pkg::FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        ez_in,
    input  logic [FRAC_W:0]         mant_in,
    input  logic [4:0]              shift_in,
    input  logic                    underflow_in,
    input  logic                    overflow_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    flag_uf,
    output logic                    flag_of,
    output logic                    flag_nx
);

    import mul_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAC_W + 2);

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [EXP_W+FRAC_W:0]  result_q, result_d;
    logic                   uf_q, uf_d, of_q, of_d, nx_q, nx_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic                   load;
    logic [CNT_W-1:0]       cnt_raw, cnt_load;
    logic [FRAC_W:0]        mant_nx;
    logic                   sticky_nx;
    logic                   done;

    denorm_shifter #(
        .MANT_W (FRAC_W + 1),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (state_q == SHIFT),
        .mant_in   (mant_in),
        .count_in  (cnt_load),
        .mant_nx   (mant_nx),
        .sticky_nx (sticky_nx),
        .done      (done)
    );

    always_comb begin
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept   = in_valid && in_ready;
        cnt_raw  = {1'b0, shift_in} + CNT_W'(1);
        cnt_load = (cnt_raw > CNT_MAX) ? CNT_MAX : cnt_raw;

        state_d     = state_q;
        sign_d      = sign_q;
        result_d    = result_q;
        uf_d        = uf_q;
        of_d        = of_q;
        nx_d        = nx_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;

        unique case (state_q)
            SHIFT: begin
                if (done) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    result_d    = {sign_q, {EXP_W{1'b0}}, mant_nx[FRAC_W-1:0]};
                    uf_d        = 1'b1;
                    of_d        = 1'b0;
                    nx_d        = sticky_nx;
                end
            end
            default: begin
                if (accept) begin
                    sign_d = sign_in;
                    if (overflow_in) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        result_d    = {sign_in, EXP_ALL_ONES, {FRAC_W{1'b0}}};
                        uf_d        = 1'b0;
                        of_d        = 1'b1;
                        nx_d        = 1'b1;
                    end else if (!underflow_in) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        result_d    = {sign_in, ez_in, mant_in[FRAC_W-1:0]};
                        uf_d        = 1'b0;
                        of_d        = 1'b0;
                        nx_d        = 1'b0;
                    end else begin
                        state_d     = SHIFT;
                        out_valid_d = 1'b0;
                        load        = 1'b1;
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            result_q    <= '0;
            uf_q        <= 1'b0;
            of_q        <= 1'b0;
            nx_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            uf_q        <= uf_d;
            of_q        <= of_d;
            nx_q        <= nx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_uf   = uf_q;
    assign flag_of   = of_q;
    assign flag_nx   = nx_q;

endmodule

// File: tb/tb_mul_result_packer.sv
// Scoreboard bench for mul_result_packer: directed corner cases plus randomized traffic with backpressure.
module tb_mul_result_packer;

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sign_in = 1'b0;
    logic [EW-1:0] ez_in = '0;
    logic [FW:0]   mant_in = '0;
    logic [4:0]    shift_in = '0;
    logic          underflow_in = 1'b0;
    logic          overflow_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW+FW:0] result;
    logic          flag_uf, flag_of, flag_nx;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    logic [35:0]   exp_q[$];
    logic          rand_rdy = 1'b0;
    logic          held_pending = 1'b0;
    logic [35:0]   held_val = '0;

    mul_result_packer #(.EXP_W(EW), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .ez_in(ez_in), .mant_in(mant_in), .shift_in(shift_in),
        .underflow_in(underflow_in), .overflow_in(overflow_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_uf(flag_uf), .flag_of(flag_of), .flag_nx(flag_nx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: {result[31:0], uf, of, nx} from the arithmetic meaning of each case.
    function automatic logic [35:0] model(input logic s, input logic [7:0] ez, input logic [23:0] m,
                                          input logic [4:0] sh, input logic uf, input logic of);
        longint unsigned full, frac, lost, c;
        if (of) return {s, 8'hFF, 23'd0, 3'b011};
        if (!uf) return {s, ez, m[22:0], 3'b000};
        c = longint'(sh) + 1;
        if (c > 25) c = 25;
        full = longint'(m);
        frac = full >> c;
        lost = full % (64'd1 << c);
        return {s, 8'h00, frac[22:0], 1'b1, 1'b0, lost != 0};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held_pending = 1'b0;
        end else begin
            if (out_valid && held_pending)
                check("hold_stable", {28'd0, result, flag_uf, flag_of, flag_nx}, {28'd0, held_val});
            held_pending = 1'b0;
            if (out_valid && !out_ready) begin
                held_pending = 1'b1;
                held_val = {result, flag_uf, flag_of, flag_nx};
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    check("result", {28'd0, result, flag_uf, flag_of, flag_nx}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic s, input logic [7:0] ez, input logic [23:0] m,
                        input logic [4:0] sh, input logic uf, input logic of);
        bit accepted = 0;
        sign_in = s; ez_in = ez; mant_in = m; shift_in = sh;
        underflow_in = uf; overflow_in = of; in_valid = 1'b1;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(s, ez, m, sh, uf, of));
                accepted = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        sign_in = ~s; ez_in = $urandom; mant_in = $urandom; shift_in = $urandom;
        underflow_in = 1'b0; overflow_in = 1'b0;
        if (!accepted) check("accept_timeout", 64'd1, 64'd0);
    endtask

    // Edges from the accept edge (inclusive) until out_valid is visible.
    task automatic wait_valid(input int limit, output int n);
        n = 1;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int spurious;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_flags", {61'd0, flag_uf, flag_of, flag_nx}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0);
        wait_valid(5, n);
        check("normal_latency", 64'(n), 64'd1);
        check("normal_value", {32'd0, result}, 64'h40400000);
        repeat (2) tick();

        send(1'b1, 8'h12, 24'hABCDEF, 5'd3, 1'b1, 1'b1);
        wait_valid(5, n);
        check("ovf_latency", 64'(n), 64'd1);
        check("ovf_value", {32'd0, result}, 64'hFF800000);
        repeat (2) tick();

        send(1'b0, 8'h00, 24'h800001, 5'd2, 1'b1, 1'b0);
        wait_valid(40, n);
        check("uf_latency", 64'(n), 64'd4);
        check("uf_value", {32'd0, result}, 64'h00100000);
        check("uf_flags", {61'd0, flag_uf, flag_of, flag_nx}, 64'b101);
        repeat (2) tick();

        out_ready = 1'b0;
        send(1'b1, 8'h7F, 24'h9A5A5A, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            tick();
        end
        out_ready = 1'b1;
        send(1'b0, 8'h81, 24'hF00000, 5'd0, 1'b0, 1'b0);
        check("b2b_value", {32'd0, result}, 64'h40F00000);
        repeat (2) tick();

        send(1'b1, 8'h00, 24'hFFFFFF, 5'd31, 1'b1, 1'b0);
        wait_valid(60, n);
        check("big_shift_latency", 64'(n), 64'd26);
        check("big_shift_value", {32'd0, result}, 64'h80000000);
        repeat (2) tick();

        send(1'b0, 8'h00, 24'hC12345, 5'd10, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", {32'd0, result}, 64'd0);
        check("midrst_flags", {61'd0, flag_uf, flag_of, flag_nx}, 64'd0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
            tick();
        end
        check("midrst_no_spurious", 64'(spurious), 64'd0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic uf, of;
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom_range(0, 9);
            of = (r == 0);
            uf = (r <= 3) || (r == 9 && $urandom_range(0, 1) == 1);
            send(1'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, 5'($urandom), uf, of);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mul_result_packer.md
MUL_RESULT_PACKER -- requirements
Module: mul_result_packer

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter FRAC_W, default 23, stored fraction width; the mantissa input is FRAC_W+1 bits (hidden bit included).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream exponent-update result valid.
REQ-006 in_ready  output  1  packer can accept an input this cycle.
REQ-007 sign_in  input  1  product sign.
REQ-008 ez_in  input  EXP_W  updated biased exponent Ez.
REQ-009 mant_in  input  FRAC_W+1  normalized product mantissa, bit FRAC_W is the hidden bit.
REQ-010 shift_in  input  5  mantissa modify count from exponent update; meaningful only with underflow_in.
REQ-011 underflow_in  input  1  exponent-update underflow flag.
REQ-012 overflow_in  input  1  exponent-update overflow flag.
REQ-013 out_valid  output  1  packed result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 result  output  1+EXP_W+FRAC_W  packed IEEE-754 word {sign, exponent, fraction}.
REQ-016 flag_uf, flag_of, flag_nx  output  1 each  underflow, overflow and inexact flags accompanying result.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and HOLD.
REQ-018 in_ready SHALL be 1 in IDLE, equal to out_ready in HOLD, and 0 in SHIFT.
REQ-019 The transfer in SHALL occur when in_valid && in_ready; the transfer out SHALL occur when out_valid && out_ready.
REQ-020 On accept with overflow_in=1: result = {sign_in, all-ones, zero fraction}, flag_of=1, flag_uf=0, flag_nx=1, next state HOLD. Overflow has priority over underflow_in.
REQ-021 On accept with neither flag set: result = {sign_in, ez_in, mant_in[FRAC_W-1:0]}, all flags 0, next state HOLD (latency 1 cycle).
REQ-022 On accept with underflow_in=1 only: load the mantissa register and a 6-bit counter with min(shift_in+1, FRAC_W+2), clear sticky, next state SHIFT.
REQ-023 In SHIFT, each cycle: mantissa >>= 1, sticky |= shifted-out bit, counter decrements. When the counter reaches 0, go to HOLD with result = {sign_in, zero exponent, mantissa[FRAC_W-1:0]}, flag_uf=1, flag_nx=sticky. Total latency is 1+count cycles.
REQ-024 Rounding SHALL be truncation; no increment is applied to the fraction.
REQ-025 In HOLD, out_valid=1. result and flags SHALL stay stable while out_ready=0.
REQ-026 In HOLD with out_ready=1 and in_valid=1, the new input SHALL be accepted in the same cycle (back-to-back, one result per cycle for non-underflow inputs). With out_ready=1 and in_valid=0, the next state SHALL be IDLE.
REQ-027 out_valid SHALL be 0 in IDLE and SHIFT.
REQ-028 sign_in SHALL be captured at accept; input changes during SHIFT or HOLD SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid=0, result=0, all flags 0, counter=0 and sticky=0.
REQ-030 Reset during SHIFT or HOLD SHALL discard the in-flight operation; no result is emitted after reset release.

Structure
REQ-031 Package mul_pkg SHALL hold EXP_W, FRAC_W, the all-ones exponent constant and the state enum type.
REQ-032 Sub-module denorm_shifter SHALL hold the mantissa shift register, sticky bit and counter, with load/step/done ports. The FSM and packing logic SHALL stay in mul_result_packer.

Verification
REQ-033 Normal case: sign 0, ez 0x80, mant 0xC00000, out_ready=1 -> result 0x40400000 one cycle after accept, flags 000.
REQ-034 Overflow case: overflow_in=1 and underflow_in=1, sign 1 -> result 0xFF800000, flag_of=1, flag_nx=1.
REQ-035 Underflow case: mant 0x800001, shift_in 2 -> after 1+3 cycles, result 0x00100000, flag_uf=1, flag_nx=1.
REQ-036 Backpressure and back-to-back: out_ready=0 for 5 cycles -> result held and in_ready=0; then out_ready=1 with in_valid=1 -> new input accepted and a fresh result appears on the next cycle.
REQ-037 Large shift: shift_in 31 -> count saturates at 25, fraction 0, flag_nx=1, out_valid after 26 cycles.
REQ-038 Mid-operation reset: assert rst_n=0 during cycle 2 of SHIFT -> out_valid=0 and result=0 immediately; no spurious out_valid after release.
